onehot_decoder_seq: RTL and testbench

ONEHOT_DECODER_SEQ -- requirements
Module: onehot_decoder_seq

---
 rtl/onehot_dec_pkg.sv | 13 +
 rtl/onehot_decoder_seq_dwell_timer.sv | 32 +++
 rtl/onehot_decoder_seq.sv | 144 ++++++++++++++
 tb/tb_onehot_decoder_seq.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/onehot_dec_pkg.sv
// rtl/onehot_dec_pkg.sv - shared state enum and mode constants for the one-hot decoder
package onehot_dec_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    SWEEP = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SWEEP  = 1'b1;

endpackage

// File: rtl/onehot_decoder_seq_dwell_timer.sv
// rtl/onehot_decoder_seq_dwell_timer.sv - dwell counter that ticks once count reaches a live limit
module dwell_timer
  import onehot_dec_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         tick
);

  logic [W-1:0] count_q;

  // >= rather than == so a limit lowered below the running count fires at once
  // instead of waiting for the counter to roll over.
  assign tick = enable & (count_q >= limit);

  // Count enabled cycles, restarting from zero on each tick or on clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= tick ? '0 : count_q + 1'b1;
    end
  end

endmodule

// File: rtl/onehot_decoder_seq.sv
// rtl/onehot_decoder_seq.sv - registered one-hot decoder with optional sweep mode (ONEHOT_DEC_SWEEP_EN)
module onehot_decoder_seq
  import onehot_dec_pkg::*;
#(
  parameter int SEL_W   = 4,
  parameter int DWELL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  sel_valid,
  input  logic [SEL_W-1:0]      sel,
  output logic                  sel_ready,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [(2**SEL_W)-1:0] out,
  output logic [SEL_W-1:0]      idx,
  output logic                  out_valid,
  output logic                  wrap
);

  localparam int OUT_W = 2**SEL_W;

  state_t             state_q, state_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic               wrap_d;
  logic               mode_eff;

  function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] i);
    decode    = '0;
    decode[i] = 1'b1;
  endfunction

`ifdef ONEHOT_DEC_SWEEP_EN
  logic tick;
  logic wrap_q;

  assign mode_eff = mode;

  dwell_timer #(
    .W(DWELL_W)
  ) u_dwell (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state_q != SWEEP),
    .enable (state_q == SWEEP),
    .limit  (dwell),
    .tick   (tick)
  );

  // Wrap flag is registered alongside out so it lines up with bit 0 reappearing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;
`else
  logic unused_cfg;

  // Direct-decode-only build: mode and dwell have no effect.
  assign mode_eff   = MODE_DIRECT;
  assign wrap       = 1'b0;
  assign unused_cfg = ^{mode, dwell, wrap_d};
`endif

  // Next state, next decode value and handshake; en low always wins.
  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    idx_d     = idx_q;
    wrap_d    = 1'b0;
    sel_ready = 1'b0;
    case (state_q)
      IDLE: begin
        sel_ready = en & (mode_eff == MODE_DIRECT);
        out_d     = '0;
        idx_d     = '0;
        if (en) begin
          if (mode_eff == MODE_SWEEP) begin
            state_d = SWEEP;
            idx_d   = '0;
            out_d   = decode('0);
          end else if (sel_valid) begin
            state_d = HOLD;
            idx_d   = sel;
            out_d   = decode(sel);
          end
        end
      end
      HOLD: begin
        sel_ready = 1'b1;
        if (!en || (mode_eff != MODE_DIRECT)) begin
          state_d = IDLE;
          out_d   = '0;
          idx_d   = '0;
        end else if (sel_valid) begin
          idx_d = sel;
          out_d = decode(sel);
        end
      end
`ifdef ONEHOT_DEC_SWEEP_EN
      SWEEP: begin
        if (!en || (mode_eff != MODE_SWEEP)) begin
          state_d = IDLE;
          out_d   = '0;
          idx_d   = '0;
        end else if (tick) begin
          idx_d  = idx_q + 1'b1;
          out_d  = decode(idx_d);
          wrap_d = (idx_q == '1);
        end
      end
`endif
      default: begin
        state_d = IDLE;
        out_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // State and registered decode outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
    end
  end

  assign out       = out_q;
  assign idx       = idx_q;
  assign out_valid = |out_q;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// tb/tb_onehot_decoder_seq.sv - directed table-driven bench for onehot_decoder_seq
module tb_onehot_decoder_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        mode;
  logic        sel_valid;
  logic [3:0]  sel;
  logic        sel_ready;
  logic [7:0]  dwell;
  logic [15:0] out;
  logic [3:0]  idx;
  logic        out_valid;
  logic        wrap;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        en;
    logic        mode;
    logic        sel_valid;
    logic [3:0]  sel;
    logic        exp_ready;
    logic [15:0] exp_out;
    logic [3:0]  exp_idx;
    logic        exp_valid;
  } vec_t;

  vec_t vecs[10];

  onehot_decoder_seq #(
    .SEL_W   (4),
    .DWELL_W (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .sel_valid (sel_valid),
    .sel       (sel),
    .sel_ready (sel_ready),
    .dwell     (dwell),
    .out       (out),
    .idx       (idx),
    .out_valid (out_valid),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string name, input logic [15:0] e_out, input logic [3:0] e_idx,
                          input logic e_valid, input logic e_wrap);
    chk({name, ".out"}, 32'(out), 32'(e_out));
    chk({name, ".idx"}, 32'(idx), 32'(e_idx));
    chk({name, ".out_valid"}, 32'(out_valid), 32'(e_valid));
    chk({name, ".wrap"}, 32'(wrap), 32'(e_wrap));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           en mode sv sel ready out      idx  valid
    vecs[0] = '{1'b0, 1'b0, 1'b1, 4'h5, 1'b0, 16'h0000, 4'h0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 4'h5, 1'b1, 16'h0000, 4'h0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 4'hA, 1'b1, 16'h0400, 4'hA, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 4'h3, 1'b1, 16'h0008, 4'h3, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 4'h9, 1'b1, 16'h0008, 4'h3, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 4'hF, 1'b1, 16'h8000, 4'hF, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 16'h0001, 4'h0, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 4'h7, 1'b1, 16'h0000, 4'h0, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 4'h7, 1'b1, 16'h0000, 4'h0, 1'b0};
    vecs[9] = '{1'b1, 1'b0, 1'b1, 4'h7, 1'b1, 16'h0080, 4'h7, 1'b1};

    rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel_valid = 1'b0; sel = 4'h0; dwell = 8'd0;
    repeat (2) @(negedge clk);
    chk_outs("reset", 16'h0000, 4'h0, 1'b0, 1'b0);
    chk("reset.sel_ready", 32'(sel_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      en = vecs[i].en; mode = vecs[i].mode; sel_valid = vecs[i].sel_valid; sel = vecs[i].sel;
      #1;
      chk($sformatf("v%0d.sel_ready", i), 32'(sel_ready), 32'(vecs[i].exp_ready));
      @(negedge clk);
      chk_outs($sformatf("v%0d", i), vecs[i].exp_out, vecs[i].exp_idx, vecs[i].exp_valid, 1'b0);
    end

    // async reset while holding 0x0080, then resume from IDLE with nothing retained
    sel_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_outs("rst_hold", 16'h0000, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_outs("rst_release", 16'h0000, 4'h0, 1'b0, 1'b0);
    sel_valid = 1'b1; sel = 4'h7;
    @(negedge clk);
    chk_outs("rehold", 16'h0080, 4'h7, 1'b1, 1'b0);
    sel_valid = 1'b0;

`ifdef ONEHOT_DEC_SWEEP_EN
    begin
      int  m_idx;
      int  m_cnt;
      int  wraps;
      logic m_wrap;

      // mode 0->1 in HOLD: one zero cycle, then sweep starts at bit 0
      dwell = 8'd2; mode = 1'b1;
      @(negedge clk);
      chk_outs("hold2sweep.gap", 16'h0000, 4'h0, 1'b0, 1'b0);
      @(negedge clk);
      chk_outs("hold2sweep.start", 16'h0001, 4'h0, 1'b1, 1'b0);
      chk("sweep.sel_ready", 32'(sel_ready), 32'd0);

      m_idx = 0; m_cnt = 0; wraps = 0;
      for (int k = 0; k < 116; k++) begin
        if (k == 96) dwell = 8'd0;
        if (m_cnt >= int'(dwell)) begin
          m_wrap = (m_idx == 15);
          m_idx  = (m_idx + 1) % 16;
          m_cnt  = 0;
        end else begin
          m_wrap = 1'b0;
          m_cnt++;
        end
        @(negedge clk);
        if (wrap) wraps++;
        chk_outs($sformatf("sweep%0d", k), 16'(1 << m_idx), 4'(m_idx), 1'b1, m_wrap);
        if (k == 95) chk("sweep.wraps_96", 32'(wraps), 32'd2);
      end

      // leave and re-enter; lower dwell 5 -> 1 while counter sits at 3
      en = 1'b0;
      @(negedge clk);
      chk_outs("sweep_off", 16'h0000, 4'h0, 1'b0, 1'b0);
      en = 1'b1; dwell = 8'd5;
      @(negedge clk);
      chk_outs("resweep", 16'h0001, 4'h0, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk_outs($sformatf("dw5_%0d", k), 16'h0001, 4'h0, 1'b1, 1'b0);
      end
      dwell = 8'd1;
      @(negedge clk);
      chk_outs("dw_lowered", 16'h0002, 4'h1, 1'b1, 1'b0);

      // async reset mid-sweep at idx 7
      dwell = 8'd0;
      for (int k = 2; k <= 7; k++) begin
        @(negedge clk);
        chk_outs($sformatf("to7_%0d", k), 16'(1 << k), 4'(k), 1'b1, 1'b0);
      end
      #2 rst_n = 1'b0;
      #1 chk_outs("rst_sweep", 16'h0000, 4'h0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_outs("rst_sweep_resume", 16'h0001, 4'h0, 1'b1, 1'b0);
    end
`else
    // direct-only build: mode and dwell have no effect
    en = 1'b0;
    @(negedge clk);
    chk_outs("nosweep.off", 16'h0000, 4'h0, 1'b0, 1'b0);
    en = 1'b1; mode = 1'b1; sel_valid = 1'b1; sel = 4'h5; dwell = 8'd3;
    #1 chk("nosweep.sel_ready", 32'(sel_ready), 32'd1);
    @(negedge clk);
    chk_outs("nosweep.sel5", 16'h0020, 4'h5, 1'b1, 1'b0);
    sel_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk_outs($sformatf("nosweep.hold%0d", k), 16'h0020, 4'h5, 1'b1, 1'b0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
